// File: rtl/spi_rx.sv
// spi_rx: SPI receive front end for the LCD link.
// Samples the asynchronous SPI pins into the clk domain and assembles
// MSB-first bytes tagged with the data/command qualifier. Completed
// {dc, byte} entries go into first-word-fall-through storage.
// Build option: define SPI_RX_FIFO_EN for a 4-entry FIFO; without it the
// storage is a single holding register.
module spi_rx (
    input  logic       clk,
    input  logic       reset_,
    input  logic       sck_in,
    input  logic       sdi,
    input  logic       cs_in_,
    input  logic       dc_in,
    input  logic       rd,
    input  logic       clr,
    output logic [8:0] dout,
    output logic       valid,
    output logic [2:0] level,
    output logic       ovf,
    output logic       ferr
);

`ifdef SPI_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchronizer chains plus the previous-sck flop for edge detection.
    logic sck_s1, sck_s2, sck_prev;
    logic cs_s1, cs_s2;
    logic sdi_s1, sdi_s2;
    logic dc_s1, dc_s2;

    // Registered edge strobe with the pin values that belong to it, so the
    // frame logic sees cs and sck events in the order they happened.
    logic rise_q, sdi_q, dc_q, cs_q;

    state_t     state, state_nxt;
    logic       shift_en, frame_start, ferr_set;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       push_q;
    logic [8:0] push_data;

    logic [8:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [2:0]       count;
    logic             full, pop, wr_en, ovf_set;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Bring the asynchronous pins into the clk domain; idle values on reset.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sck_s1   <= 1'b1;
            sck_s2   <= 1'b1;
            sck_prev <= 1'b1;
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            sdi_s1   <= 1'b0;
            sdi_s2   <= 1'b0;
            dc_s1    <= 1'b0;
            dc_s2    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of its source, which is what a chain needs.
            sck_s1   <= sck_in;
            sck_s2   <= sck_s1;
            sck_prev <= sck_s2;
            cs_s1    <= cs_in_;
            cs_s2    <= cs_s1;
            sdi_s1   <= sdi;
            sdi_s2   <= sdi_s1;
            dc_s1    <= dc_in;
            dc_s2    <= dc_s1;
        end
    end

    // Register the sck rising-edge strobe together with its data and cs.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rise_q <= 1'b0;
            sdi_q  <= 1'b0;
            dc_q   <= 1'b0;
            cs_q   <= 1'b1;
        end else begin
            rise_q <= sck_s2 & ~sck_prev;
            sdi_q  <= sdi_s2;
            dc_q   <= dc_s2;
            cs_q   <= cs_s2;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= state_nxt;
    end

    // Frame next-state and control strobes.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned,
        // which would otherwise infer a latch.
        state_nxt   = state;
        shift_en    = 1'b0;
        frame_start = 1'b0;
        ferr_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_q) begin
                    state_nxt   = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_q) begin
                    state_nxt = IDLE;
                    ferr_set  = (bit_cnt != 3'd0);
                end else if (rise_q) begin
                    shift_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift in bits; the eighth bit hands the completed entry to storage.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            push_q    <= 1'b0;
            push_data <= 9'h000;
        end else begin
            push_q <= 1'b0;
            if (frame_start) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[6:0], sdi_q};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    push_q    <= 1'b1;
                    push_data <= {dc_q, shift_reg[6:0], sdi_q};
                end
            end
        end
    end

    assign full    = (count == 3'(DEPTH));
    assign pop     = rd && (count != 3'd0);
    assign wr_en   = push_q && (!full || pop);
    assign ovf_set = push_q && full && !pop;

    // Storage array write port.
    // NOTE: the array has no reset; count defines which entries are live
    // and dout is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; a simultaneous push and pop keeps the level.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            if (wr_en && !pop)      count <= count + 3'd1;
            else if (pop && !wr_en) count <= count - 3'd1;
        end
    end

    // Sticky error flags; a set event beats a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ovf  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovf_set)  ovf <= 1'b1;
            else if (clr) ovf <= 1'b0;
            if (ferr_set) ferr <= 1'b1;
            else if (clr) ferr <= 1'b0;
        end
    end

    assign valid = (count != 3'd0);
    assign level = count;
    assign dout  = valid ? mem[rd_ptr] : 9'h000;

endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: randomized and directed bench for spi_rx.
// A transaction-level model watches the SPI pins, assembles bytes from the
// frame rules and keeps the expected storage contents in a queue.
module tb_spi_rx;

`ifdef SPI_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int LAT_PUSH = 4;  // sampling edge of 8th sck rise -> entry visible
    localparam int LAT_FERR = 3;  // sampling edge of cs rise -> ferr visible
    localparam int HALF     = 5;  // clk cycles per sck phase

    logic       clk    = 1'b0;
    logic       reset_ = 1'b0;
    logic       sck_in = 1'b1;
    logic       sdi    = 1'b0;
    logic       cs_in_ = 1'b1;
    logic       dc_in  = 1'b0;
    logic       rd     = 1'b0;
    logic       clr    = 1'b0;
    logic [8:0] dout;
    logic       valid;
    logic [2:0] level;
    logic       ovf;
    logic       ferr;

    int vectors     = 0;
    int miscompares = 0;
    bit rand_mode   = 1'b0;

    spi_rx dut (
        .clk    (clk),
        .reset_ (reset_),
        .sck_in (sck_in),
        .sdi    (sdi),
        .cs_in_ (cs_in_),
        .dc_in  (dc_in),
        .rd     (rd),
        .clr    (clr),
        .dout   (dout),
        .valid  (valid),
        .level  (level),
        .ovf    (ovf),
        .ferr   (ferr)
    );

    always #8 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        bit         is_ferr;
        logic [8:0] data;
    } ev_t;

    ev_t        pend[$];
    logic [8:0] mq[$];
    int         cyc      = 0;
    bit         m_ovf    = 1'b0;
    bit         m_ferr   = 1'b0;
    bit         p_sck    = 1'b1;
    bit         p_cs     = 1'b1;
    bit         in_frame = 1'b0;
    int         nbits    = 0;
    logic [7:0] acc      = 8'h00;

    initial begin
        bit         do_push, do_ferr, do_pop, ovf_ev;
        logic [8:0] pdata;
        forever begin
            @(posedge clk or negedge reset_);
            if (!reset_) begin
                pend.delete();
                mq.delete();
                m_ovf = 1'b0; m_ferr = 1'b0;
                p_sck = 1'b1; p_cs = 1'b1;
                in_frame = 1'b0; nbits = 0; acc = 8'h00;
            end else begin
                cyc++;
                do_push = 1'b0; do_ferr = 1'b0; pdata = 9'h000;
                for (int i = pend.size() - 1; i >= 0; i--) begin
                    if (pend[i].due == cyc) begin
                        if (pend[i].is_ferr) do_ferr = 1'b1;
                        else begin do_push = 1'b1; pdata = pend[i].data; end
                        pend.delete(i);
                    end
                end
                do_pop = rd && (mq.size() > 0);
                ovf_ev = do_push && (mq.size() == DEPTH) && !do_pop;
                if (do_pop) void'(mq.pop_front());
                if (do_push && !ovf_ev) mq.push_back(pdata);
                m_ovf  = ovf_ev  ? 1'b1 : (clr ? 1'b0 : m_ovf);
                m_ferr = do_ferr ? 1'b1 : (clr ? 1'b0 : m_ferr);
                // Frame rules applied to the pin values seen at this edge.
                if (p_cs && !cs_in_) begin
                    in_frame = 1'b1;
                    nbits    = 0;
                end else if (!p_cs && cs_in_) begin
                    if (in_frame && (nbits % 8) != 0)
                        pend.push_back('{cyc + LAT_FERR, 1'b1, 9'h000});
                    in_frame = 1'b0;
                end else if (in_frame && !cs_in_ && !p_sck && sck_in) begin
                    acc = {acc[6:0], sdi};
                    nbits++;
                    if ((nbits % 8) == 0)
                        pend.push_back('{cyc + LAT_PUSH, 1'b0, {dc_in, acc}});
                end
                p_sck = sck_in;
                p_cs  = cs_in_;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_dout",  dout, (mq.size() > 0) ? mq[0] : 9'h000);
        check("model_valid", 9'(valid), 9'(mq.size() != 0));
        check("model_level", 9'(level), 9'(mq.size()));
        check("model_ovf",   9'(ovf),   9'(m_ovf));
        check("model_ferr",  9'(ferr),  9'(m_ferr));
    endtask

    task automatic expect_out(input string name, input logic [8:0] d, input logic v,
                              input logic [2:0] l, input logic o, input logic f);
        check({name, "_dout"},  dout,      d);
        check({name, "_valid"}, 9'(valid), 9'(v));
        check({name, "_level"}, 9'(level), 9'(l));
        check({name, "_ovf"},   9'(ovf),   9'(o));
        check({name, "_ferr"},  9'(ferr),  9'(f));
    endtask

    // One clk cycle: compare on the falling edge, then drive new inputs.
    task automatic tick();
        @(negedge clk);
        if (reset_) compare_model();
        if (rand_mode) begin
            rd  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 40) == 0);
        end
    endtask

    task automatic pop_one();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic clear_flags();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic frame_start(input logic dc);
        dc_in  = dc;
        cs_in_ = 1'b0;
        repeat (HALF) tick();
    endtask

    task automatic frame_end();
        cs_in_ = 1'b1;
        repeat (HALF + 2) tick();
    endtask

    // Send the n most significant bits of b. rd_push raises rd exactly in
    // the cycle the last bit's entry is pushed; chk_lat pins that latency.
    task automatic send_bits(input logic [7:0] b, input int n, input bit rd_push,
                             input bit chk_lat, input logic [8:0] lat_exp);
        for (int i = 0; i < n; i++) begin
            sck_in = 1'b0;
            sdi    = b[7-i];
            repeat (HALF) tick();
            sck_in = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                tick();
                if (i == n - 1) begin
                    if (rd_push) rd = (k == LAT_PUSH);
                    if (chk_lat && k == LAT_PUSH)
                        check("lat_before", 9'(valid), 9'h000);
                    if (chk_lat && k == LAT_PUSH + 1) begin
                        check("lat_valid", 9'(valid), 9'h001);
                        check("lat_dout",  dout, lat_exp);
                    end
                end
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        expect_out("reset", 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);
        reset_ = 1'b1;
        repeat (3) tick();

        // Single data byte with exact latency.
        frame_start(1'b1);
        send_bits(8'hA5, 8, 1'b0, 1'b1, 9'h1A5);
        frame_end();
        expect_out("a5", 9'h1A5, 1'b1, 3'd1, 1'b0, 1'b0);
        pop_one();
        expect_out("a5_pop", 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);

        // Two command bytes in one frame.
        frame_start(1'b0);
        send_bits(8'h3C, 8, 1'b0, 1'b0, 9'h000);
        send_bits(8'h81, 8, 1'b0, 1'b0, 9'h000);
        frame_end();
`ifdef SPI_RX_FIFO_EN
        expect_out("two_head", 9'h03C, 1'b1, 3'd2, 1'b0, 1'b0);
        pop_one();
        expect_out("two_next", 9'h081, 1'b1, 3'd1, 1'b0, 1'b0);
        pop_one();
        expect_out("two_empty", 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);
`else
        expect_out("two_head", 9'h03C, 1'b1, 3'd1, 1'b1, 1'b0);
        pop_one();
        expect_out("two_empty", 9'h000, 1'b0, 3'd0, 1'b1, 1'b0);
`endif
        clear_flags();

        // Overflow: five bytes with no reads.
        frame_start(1'b1);
        for (int i = 1; i <= 5; i++) send_bits(8'(i), 8, 1'b0, 1'b0, 9'h000);
        frame_end();
        for (int i = 0; i < DEPTH; i++) begin
            expect_out("ovf_pop", 9'(9'h101 + i), 1'b1, 3'(DEPTH - i), 1'b1, 1'b0);
            pop_one();
        end
        expect_out("ovf_empty", 9'h000, 1'b0, 3'd0, 1'b1, 1'b0);
        clear_flags();
        expect_out("ovf_clr", 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);

        // Full storage with a pop in the push cycle.
        frame_start(1'b0);
        for (int i = 0; i < DEPTH; i++) send_bits(8'(8'h10 + i), 8, 1'b0, 1'b0, 9'h000);
        send_bits(8'hEE, 8, 1'b1, 1'b0, 9'h000);
        frame_end();
        for (int i = 0; i < DEPTH; i++) begin
            expect_out("fullrd", (i == DEPTH - 1) ? 9'h0EE : 9'(9'h011 + i),
                       1'b1, 3'(DEPTH - i), 1'b0, 1'b0);
            pop_one();
        end

        // Partial frame sets ferr; clr clears it; next byte is clean.
        frame_start(1'b1);
        send_bits(8'hFF, 5, 1'b0, 1'b0, 9'h000);
        frame_end();
        expect_out("ferr", 9'h000, 1'b0, 3'd0, 1'b0, 1'b1);
        clear_flags();
        expect_out("ferr_clr", 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);
        frame_start(1'b1);
        send_bits(8'h7E, 8, 1'b0, 1'b0, 9'h000);
        frame_end();
        expect_out("after_ferr", 9'h17E, 1'b1, 3'd1, 1'b0, 1'b0);

        // Reset three bits into a frame while an entry is stored.
        frame_start(1'b1);
        send_bits(8'hE0, 3, 1'b0, 1'b0, 9'h000);
        @(negedge clk);
        #2 reset_ = 1'b0;
        #1 expect_out("mid_reset", 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);
        cs_in_ = 1'b1;
        sck_in = 1'b1;
        repeat (4) tick();
        #2 reset_ = 1'b1;
        repeat (3) tick();
        expect_out("post_reset_idle", 9'h000, 1'b0, 3'd0, 1'b0, 1'b0);
        frame_start(1'b1);
        send_bits(8'h55, 8, 1'b0, 1'b0, 9'h000);
        frame_end();
        expect_out("post_reset", 9'h155, 1'b1, 3'd1, 1'b0, 1'b0);
        pop_one();

        // Randomized frames, reads and clears against the model.
        rand_mode = 1'b1;
        for (int f = 0; f < 60; f++) begin
            nb = $urandom_range(1, 3);
            frame_start(1'($urandom_range(0, 1)));
            for (int j = 0; j < nb; j++) send_bits(8'($urandom), 8, 1'b0, 1'b0, 9'h000);
            if ($urandom_range(0, 3) == 0)
                send_bits(8'($urandom), $urandom_range(1, 7), 1'b0, 1'b0, 9'h000);
            frame_end();
        end
        rand_mode = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 8 && valid; i++) pop_one();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
